// File: rtl/gettanh_call_arbiter_pkg.sv
// ============================================================================
// Module : gettanh_arb_pkg
// Brief  : Shared widths and round-robin pick function for the getTanh arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gettanh_arb_pkg;

    // Requester-ID width; never narrower than one bit so 2-requester builds work.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of valid scanning ptr, ptr+1, ... modulo n (n <= 16).
    function automatic logic [3:0] rr_pick(input logic [15:0] valid,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = (int'(ptr) + k) % n;
            if (!found && (k < n) && valid[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gettanh_call_arbiter_if.sv
// ============================================================================
// Module : gettanh_call_arbiter_if
// Brief  : Client call/response channels plus the shared component handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gettanh_call_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] resp_valid;
    logic [NUM_REQ-1:0] resp_ready;
    logic [DATA_W-1:0]  resp_data;
    logic               comp_start;
    logic               comp_busy;
    logic               comp_done;
    logic               comp_stall;
    logic [DATA_W-1:0]  comp_data;

    // Arbiter side
    modport slave (
        input  req_valid, resp_ready, comp_busy, comp_done, comp_data,
        output req_ready, resp_valid, resp_data, comp_start, comp_stall
    );

    // Clients together with the component
    modport master (
        output req_valid, resp_ready, comp_busy, comp_done, comp_data,
        input  req_ready, resp_valid, resp_data, comp_start, comp_stall
    );
endinterface

`default_nettype wire

// File: rtl/gettanh_call_arbiter_tag_fifo.sv
// ============================================================================
// Module : gettanh_tag_fifo
// Brief  : First-word-fall-through FIFO of requester IDs for issued calls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gettanh_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  wire logic                       clock,
    input  wire logic                       resetn,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           din,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           head,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/gettanh_call_arbiter.sv
// ============================================================================
// Module : gettanh_call_arbiter
// Brief  : Round-robin sharing of one getTanh component among NUM_REQ clients.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gettanh_call_arbiter
    import gettanh_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  wire logic                              clock,
    input  wire logic                              resetn,
    gettanh_call_arbiter_if.slave                  bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight,
    output logic                                   proto_err
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    head;
    logic [15:0]        valid_ext;
    logic [3:0]         ptr_ext;
    logic [3:0]         pick;
    logic               full;
    logic               empty;
    logic               issue;
    logic               pop;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] head_oh;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = bus.req_valid;
        ptr_ext                  = '0;
        ptr_ext[ID_W-1:0]        = rr_ptr;
        pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
        grant                    = pick[ID_W-1:0];
        grant_oh                 = '0;
        grant_oh[grant]          = 1'b1;
        head_oh                  = '0;
        head_oh[head]            = 1'b1;
    end

    // Full blocks a start even when a pop happens in the same cycle.
    assign bus.comp_start = (|bus.req_valid) && !full;
    assign issue          = bus.comp_start && !bus.comp_busy;
    assign bus.req_ready  = issue ? grant_oh : '0;

    assign bus.resp_valid = (bus.comp_done && !empty) ? head_oh : '0;
    assign bus.resp_data  = bus.comp_data;
    assign bus.comp_stall = empty || !bus.resp_ready[head];
    assign pop            = bus.comp_done && !bus.comp_stall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (issue)
                rr_ptr <= ID_W'((int'(grant) + 1) % NUM_REQ);
            if (bus.comp_done && empty)
                proto_err <= 1'b1;
        end
    end

    gettanh_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (issue),
        .din    (grant),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (inflight)
    );

endmodule

`default_nettype wire
